// File: rtl/pin_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : pin_pattern_gen
// Purpose  : Board-bring-up pattern generator. Drives N_PINS header pins with
//            one of four test patterns. It also debounces two user buttons:
//            button1 steps the mode, and button2 pauses or resumes stepping.
// Ports    : clk      - system clock
//            reset_n  - asynchronous active-low reset
//            button1  - raw mode button (active-high, asynchronous)
//            button2  - raw pause button (active-high, asynchronous)
//            pins     - registered pattern outputs [N_PINS-1:0]
//            mode     - current mode: 0 BLINK, 1 WALK, 2 COUNT, 3 BREATHE
//            paused   - 1 while pattern stepping is frozen
//            led1     - debounced button1 level
//            led2     - mirrors paused
// Revision : 1.0  initial release
// ============================================================================
module pin_pattern_gen #(
   parameter int N_PINS          = 48,
   parameter int TICK_DIV        = 12_000_000,
   parameter int DEBOUNCE_CYCLES = 120_000,
   parameter int PWM_BITS        = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              button1,
   input  logic              button2,
   output logic [N_PINS-1:0] pins,
   output logic [1:0]        mode,
   output logic              paused,
   output logic              led1,
   output logic              led2
);

   localparam logic [1:0] c_MODE_BLINK   = 2'd0;
   localparam logic [1:0] c_MODE_WALK    = 2'd1;
   localparam logic [1:0] c_MODE_COUNT   = 2'd2;
   localparam logic [1:0] c_MODE_BREATHE = 2'd3;

   localparam int c_PS_W  = $clog2(TICK_DIV);
   localparam int c_IDX_W = $clog2(N_PINS);
   localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [c_PS_W-1:0]   c_PS_LAST  = c_PS_W'(TICK_DIV - 1);
   localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(N_PINS - 1);
   localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] c_DUTY_MAX = '1;
   localparam logic [PWM_BITS-1:0] c_DUTY_ONE = PWM_BITS'(1);
   localparam logic [N_PINS-1:0]   c_ONE_HOT0 = N_PINS'(1);

   // ------------------------------------------------------------------------
   // Button conditioning: 2-FF synchroniser, then a counter that accepts the
   // new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   // ------------------------------------------------------------------------
   logic [1:0] w_raw;
   logic [1:0] w_level;
   logic [1:0] w_press;

   assign w_raw = {button2, button1};

   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic              r_sync1;
      logic              r_sync2;
      logic              r_level;
      logic              r_level_d;
      logic [c_DB_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
         end else begin
            r_sync1   <= w_raw[gi];
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 != r_level) begin
               if (r_cnt == c_DB_LAST) begin
                  r_level <= r_sync2;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end else begin
               // Any sample that agrees with the current level is a bounce.
               r_cnt <= '0;
            end
         end
      end

      assign w_level[gi] = r_level;
      // One-cycle pulse on the debounced rising edge.
      assign w_press[gi] = r_level & ~r_level_d;
   end

   // ------------------------------------------------------------------------
   // Mode state machine: state register / next-state / output decode.
   // ------------------------------------------------------------------------
   logic [1:0] r_mode;
   logic [1:0] w_mode_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_mode <= c_MODE_BLINK;
      else          r_mode <= w_mode_next;
   end

   always_comb begin
      w_mode_next = r_mode;
      if (w_press[0]) begin
         case (r_mode)
            c_MODE_BLINK:   w_mode_next = c_MODE_WALK;
            c_MODE_WALK:    w_mode_next = c_MODE_COUNT;
            c_MODE_COUNT:   w_mode_next = c_MODE_BREATHE;
            default:        w_mode_next = c_MODE_BLINK;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Pause, prescaler and per-mode step state.
   // ------------------------------------------------------------------------
   logic                r_paused;
   logic [c_PS_W-1:0]   r_presc;
   logic                r_blink;
   logic [c_IDX_W-1:0]  r_idx;
   logic [N_PINS-1:0]   r_count;
   logic [PWM_BITS-1:0] r_duty;
   logic                r_dir_down;
   logic [PWM_BITS-1:0] r_pwm;
   logic                w_tick;

   // A mode change suppresses a coincident tick so the new mode starts clean.
   assign w_tick = !r_paused && !w_press[0] && (r_presc == c_PS_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_paused <= 1'b0;
         r_pwm    <= '0;
      end else begin
         r_paused <= r_paused ^ w_press[1];
         r_pwm    <= r_pwm + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc    <= '0;
         r_blink    <= 1'b0;
         r_idx      <= '0;
         r_count    <= '0;
         r_duty     <= '0;
         r_dir_down <= 1'b0;
      end else if (w_press[0]) begin
         r_presc    <= '0;
         r_blink    <= 1'b0;
         r_idx      <= '0;
         r_count    <= '0;
         r_duty     <= '0;
         r_dir_down <= 1'b0;
      end else if (w_tick) begin
         r_presc <= '0;
         case (r_mode)
            c_MODE_BLINK: r_blink <= ~r_blink;
            c_MODE_WALK:  r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            c_MODE_COUNT: r_count <= r_count + 1'b1;
            default: begin
               // Triangle sweep; direction flips on reaching either end.
               if (!r_dir_down) begin
                  r_duty <= r_duty + 1'b1;
                  if (r_duty == c_DUTY_MAX - c_DUTY_ONE) r_dir_down <= 1'b1;
               end else begin
                  r_duty <= r_duty - 1'b1;
                  if (r_duty == c_DUTY_ONE) r_dir_down <= 1'b0;
               end
            end
         endcase
      end else if (!r_paused) begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Output decode (registered pins).
   // ------------------------------------------------------------------------
   logic [N_PINS-1:0] w_pins_next;
   logic [N_PINS-1:0] r_pins;

   always_comb begin
      w_pins_next = '0;
      case (r_mode)
         c_MODE_BLINK:   w_pins_next = {N_PINS{r_blink}};
         c_MODE_WALK:    w_pins_next = c_ONE_HOT0 << r_idx;
         c_MODE_COUNT:   w_pins_next = r_count;
         c_MODE_BREATHE: w_pins_next = {N_PINS{r_pwm < r_duty}};
         default:        w_pins_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_pins <= '0;
      else          r_pins <= w_pins_next;
   end

   assign pins   = r_pins;
   assign mode   = r_mode;
   assign paused = r_paused;
   assign led1   = w_level[0];
   assign led2   = r_paused;

endmodule
`default_nettype wire

// File: tb/tb_pin_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pin_pattern_gen
// Purpose  : Self-checking bench for pin_pattern_gen. A behavioural model
//            tracks the ticks elapsed since the last mode change and derives
//            each pattern from that count arithmetically. Button levels come
//            from windows of sampled history.
// Revision : 1.0  initial release
// ============================================================================
module tb_pin_pattern_gen;

   localparam int N  = 8;
   localparam int TD = 4;
   localparam int DB = 3;
   localparam int PB = 3;
   localparam int DMAX = (1 << PB) - 1;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         button1 = 1'b0;
   logic         button2 = 1'b0;
   logic [N-1:0] pins;
   logic [1:0]   mode;
   logic         paused;
   logic         led1;
   logic         led2;

   always #5 clk = ~clk;

   pin_pattern_gen #(
      .N_PINS(N), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB)
   ) dut (
      .clk(clk), .reset_n(reset_n), .button1(button1), .button2(button2),
      .pins(pins), .mode(mode), .paused(paused), .led1(led1), .led2(led2)
   );

   int checks = 0;
   int errors = 0;

   // model state (values as they stand between clock edges)
   int           m_mode, m_ticks, m_phase, m_pwm;
   bit           m_paused;
   bit           m_lvl   [2];
   bit           m_lvl_d [2];
   logic [15:0]  m_rawh  [2];
   logic [15:0]  m_seenh [2];
   logic [N-1:0] m_pins;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] pattern(input int md, input int tk, input int pw);
      logic [N-1:0] one;
      int t, d;
      one = 1;
      case (md)
         0: return (tk % 2 == 1) ? '1 : '0;
         1: return one << (tk % N);
         2: return N'(tk);
         default: begin
            t = tk % (2 * DMAX);
            d = (t <= DMAX) ? t : 2 * DMAX - t;
            return (pw < d) ? '1 : '0;
         end
      endcase
   endfunction

   task automatic model_reset();
      m_mode = 0; m_ticks = 0; m_phase = 0; m_pwm = 0; m_paused = 0; m_pins = '0;
      for (int b = 0; b < 2; b++) begin
         m_lvl[b] = 0; m_lvl_d[b] = 0; m_rawh[b] = '0; m_seenh[b] = '0;
      end
   endtask

   task automatic model_edge();
      bit p1, p2, tick, raw, seen;
      logic [DB-1:0] win;
      p1   = m_lvl[0] & ~m_lvl_d[0];
      p2   = m_lvl[1] & ~m_lvl_d[1];
      tick = !m_paused && !p1 && (m_phase == TD - 1);
      m_pins = pattern(m_mode, m_ticks, m_pwm);
      if (p1) begin
         m_mode = (m_mode + 1) % 4; m_ticks = 0; m_phase = 0;
      end else if (!m_paused) begin
         m_phase = (m_phase + 1) % TD;
         if (tick) m_ticks++;
      end
      if (p2) m_paused = !m_paused;
      m_pwm = (m_pwm + 1) % (1 << PB);
      for (int b = 0; b < 2; b++) begin
         raw = (b == 0) ? button1 : button2;
         m_lvl_d[b] = m_lvl[b];
         m_rawh[b]  = {m_rawh[b][14:0], raw};
         seen       = m_rawh[b][2];                 // raw value two edges old
         m_seenh[b] = {m_seenh[b][14:0], seen};
         win        = m_seenh[b][DB-1:0];
         if (win == {DB{~m_lvl[b]}}) m_lvl[b] = !m_lvl[b];
      end
   endtask

   task automatic check_outputs(input string ctx);
      chk({ctx, ":pins"},   32'(pins),   32'(m_pins));
      chk({ctx, ":mode"},   32'(mode),   32'(m_mode));
      chk({ctx, ":paused"}, 32'(paused), 32'(m_paused));
      chk({ctx, ":led1"},   32'(led1),   32'(m_lvl[0]));
      chk({ctx, ":led2"},   32'(led2),   32'(m_paused));
   endtask

   // Drive inputs at a falling edge, advance one rising edge, check at the next falling edge.
   task automatic step(input bit b1, input bit b2, input string ctx);
      button1 = b1;
      button2 = b2;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs(ctx);
   endtask

   task automatic press(input bit b1, input bit b2, input string ctx);
      for (int i = 0; i < 7; i++) step(b1, b2, ctx);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, ctx);
   endtask

   task automatic apply_reset(input string ctx);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_outputs({ctx, ":async"});
      @(negedge clk);
      @(negedge clk);
      button1 = 1'b0;
      button2 = 1'b0;
      reset_n = 1'b1;
   endtask

   logic [N-1:0] held;
   int           start_mode;

   initial begin
      model_reset();
      // 1: reset values, then free-running blink
      repeat (3) @(negedge clk);
      check_outputs("reset");
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "blink");

      // 2: button1 held 10 cycles; mode flips on the sixth edge
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 1'b0, "walk_press");
         chk("mode_latency", 32'(mode), (i >= 6) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, "walk");

      // 3: short glitch is ignored, then three presses wrap to mode 0
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, "glitch");
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, "glitch");
         chk("glitch_led1", 32'(led1), 32'd0);
      end
      press(1'b1, 1'b0, "to_count");
      chk("mode_count", 32'(mode), 32'd2);
      press(1'b1, 1'b0, "to_breathe");
      press(1'b1, 1'b0, "to_blink");
      chk("mode_wrap", 32'(mode), 32'd0);

      // 4: count mode, pause freezes pins, second press resumes
      press(1'b1, 1'b0, "to_walk");
      press(1'b1, 1'b0, "to_count");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "count");
      press(1'b0, 1'b1, "pause");
      chk("paused_set", 32'(paused), 32'd1);
      held = m_pins;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0, "frozen");
         chk("frozen_pins", 32'(pins), 32'(held));
      end
      press(1'b0, 1'b1, "resume");
      chk("paused_clr", 32'(paused), 32'd0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "count_run");

      // 5: breathe through a full up/down sweep
      press(1'b1, 1'b0, "to_breathe");
      for (int i = 0; i < 130; i++) step(1'b0, 1'b0, "breathe");

      // 6: async reset mid-walk, then simultaneous presses
      press(1'b1, 1'b0, "to_blink");
      press(1'b1, 1'b0, "to_walk");
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, "walk2");
      apply_reset("mid_walk");
      chk("rst_pins", 32'(pins), 32'd0);
      chk("rst_mode", 32'(mode), 32'd0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "post_rst");
      start_mode = m_mode;
      press(1'b1, 1'b1, "both");
      chk("both_mode", 32'(mode), 32'd1);
      chk("both_paused", 32'(paused), 32'd1);
      press(1'b0, 1'b1, "unpause");

      // random segments of held button levels, with occasional resets
      for (int seg = 0; seg < 300; seg++) begin
         bit b1, b2;
         int len;
         if ($urandom_range(0, 39) == 0) begin
            apply_reset("rand");
         end else begin
            b1  = $urandom_range(0, 1) == 1;
            b2  = $urandom_range(0, 3) == 0;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) step(b1, b2, "rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
